section_mean_calibrator: RTL and testbench
==========================================

// Module: section_mean_calibrator
// PURPOSE
//  Foreground calibration controller for the 4-section interleaved ADC path.
//  Drives the running section index, accumulates 2^LOG2_AVG samples per
//  section, and writes the per-section mean coefficients (ufix32) consumed by
//  the per-section mean selection mux. Sits between the ADC sample stream and
//  the coefficient consumers; one calibration run per cal_start request.
// PARAMETERS
//  DATA_W    16  width of unsigned ADC sample
//  LOG2_AVG  10  log2 of samples averaged per section (1..16)
//  MEAN_W    32  width of each mean coefficient output (>= DATA_W)
// PORTS
//  clk            in   1       system clock, all logic rising-edge
//  rst_n          in   1       synchronous reset, active-low
//  cal_start      in   1       1-cycle request to start a calibration run
//  cal_abort      in   1       abandon run; coefficients keep previous values
//  sample_valid   in   1       sample_data valid this cycle
//  sample_data    in   DATA_W  unsigned ADC sample of section adc_section
//  adc_section    out  2       section index of the current/next valid sample
//  cal_busy       out  1       high from accepted start until DONE
//  cal_done       out  1       1-cycle pulse when new coefficients written
//  mean_valid     out  1       sticky: at least one run has completed
//  mean_1..mean_4 out  MEAN_W  coefficients for sections 0..3
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, state IDLE, accumulators 0.
//  adc_section: 2-bit counter, +1 on every sample_valid in any state, 3->0
//   wrap; sample_data on a valid cycle belongs to current adc_section value.
//  FSM states: IDLE, ALIGN, ACCUM, UPDATE.
//   IDLE:  cal_start=1 -> clear 4 accumulators and set counter to 0;
//          go to ALIGN. cal_busy rises the cycle after the start is accepted.
//   ALIGN: wait for valid sample with adc_section==0; that sample is the first
//          accumulated one (transition to ACCUM happens on that same edge).
//   ACCUM: acc[adc_section] += sample_data on each valid; set counter increments
//          when a section-3 sample is taken; after set 2^LOG2_AVG-1 is completed
//          (last section-3 sample) -> UPDATE.
//   UPDATE (1 cycle): mean_k <= zero-extend(acc[k-1] >> LOG2_AVG) to MEAN_W,
//          truncation (no rounding); cal_done=1, mean_valid<=1, cal_busy<=0;
//          -> IDLE.
//  Accumulator width DATA_W+LOG2_AVG: cannot overflow; no saturation needed.
//  Latency: cal_done asserts the cycle after the 4*2^LOG2_AVG-th accumulated
//   valid sample.
//  mean_1..4 change only in UPDATE; stable otherwise (incl. during a run).
//  cal_start while cal_busy: ignored (no restart, no queuing).
//  cal_abort (any state but IDLE): -> IDLE next cycle, cal_busy=0, no cal_done,
//   means and mean_valid unchanged. cal_abort has priority over cal_start and
//   over the UPDATE transition (abort in the cycle entering UPDATE wins).
//  cal_abort and cal_start same cycle in IDLE: start ignored.
//  sample_valid gaps: any number of idle cycles allowed; FSM holds state.
//  Reset mid-run: immediate return to reset values; mean_valid cleared.
// STRUCTURE
//  Shared package: FSM state encodings (IDLE/ALIGN/ACCUM/UPDATE),
//   NUM_SECT=4, SECT_W=2 constants.
//  One sub-module natural: section_accumulator (one acc register, clear, add-en,
//   DATA_W+LOG2_AVG wide), instantiated 4x; FSM and counters stay in top.
// TESTING (LOG2_AVG=2 unless stated)
//  1 Constant per section 100,200,300,400, continuous valid, start -> after 16
//    samples cal_done pulse, mean_1..4 = 100,200,300,400, mean_valid=1.
//  2 Section0 samples 1,2,2,2 (others 0) -> mean_1=1 (7>>2, truncation);
//    DATA_W max 65535 all samples, LOG2_AVG=10 -> mean=65535, no overflow.
//  3 Start when adc_section=2 -> first two valids discarded, accumulation
//    begins at section 0; random 50% valid gaps give same means as test 1.
//  4 Abort after 8 samples with prior means 100..400 -> no cal_done, means
//    unchanged, cal_busy=0; new start completes normally with new data.
//  5 cal_start pulsed during ACCUM -> ignored, single cal_done after 16 samples;
//    abort+start same cycle in IDLE -> stays IDLE.
//  6 rst_n low mid-ACCUM -> all outputs 0 next edge incl. mean_valid;
//    adc_section wraps 3->0 verified over 8 valids.

Source files
------------

// File: rtl/section_mean_calibrator_pkg.sv
// Shared constants and FSM encoding for the interleaved-ADC section mean calibrator.
package section_mean_calibrator_pkg;

  localparam int NUM_SECT = 4;
  localparam int SECT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_UPDATE = 2'd3
  } cal_state_t;

endpackage

// File: rtl/section_accumulator.sv
// One per-section sample accumulator; acc_d exposes the value the register takes
// at the next edge so the top can latch a final mean without waiting a cycle.
module section_accumulator
  import section_mean_calibrator_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] din,
  output logic [ACC_W-1:0]  acc_q,
  output logic [ACC_W-1:0]  acc_d
);

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + ACC_W'(din);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/section_mean_calibrator.sv
// Foreground calibration controller: tracks the ADC section, averages 2^LOG2_AVG
// samples per section and publishes the four section mean coefficients.
module section_mean_calibrator
  import section_mean_calibrator_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LOG2_AVG = 10,
  parameter int MEAN_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cal_start,
  input  logic              cal_abort,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [SECT_W-1:0] adc_section,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              mean_valid,
  output logic [MEAN_W-1:0] mean_1,
  output logic [MEAN_W-1:0] mean_2,
  output logic [MEAN_W-1:0] mean_3,
  output logic [MEAN_W-1:0] mean_4
);

  localparam int ACC_W = DATA_W + LOG2_AVG;

  cal_state_t          state;
  logic [LOG2_AVG-1:0] set_cnt;
  logic [ACC_W-1:0]    acc_q [NUM_SECT];
  logic [ACC_W-1:0]    acc_d [NUM_SECT];
  logic [NUM_SECT-1:0] add_en;
  logic [MEAN_W-1:0]   mean_r [NUM_SECT];
  logic                acc_clr;
  logic                acc_take;
  logic                last_sect;

  function automatic logic [MEAN_W-1:0] trunc_mean(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] quot;
    quot = acc >> LOG2_AVG;
    return MEAN_W'(quot);
  endfunction

  // Abort blocks both a start in IDLE and any accumulation in a run.
  assign acc_clr   = (state == ST_IDLE) && cal_start && !cal_abort;
  assign acc_take  = sample_valid && !cal_abort &&
                     ((state == ST_ACCUM) || ((state == ST_ALIGN) && (adc_section == '0)));
  assign last_sect = (adc_section == SECT_W'(NUM_SECT - 1));

  for (genvar k = 0; k < NUM_SECT; k++) begin : g_acc
    assign add_en[k] = acc_take && (adc_section == SECT_W'(k));

    section_accumulator #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .add_en (add_en[k]),
      .din    (sample_data),
      .acc_q  (acc_q[k]),
      .acc_d  (acc_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_section <= '0;
    end else if (sample_valid) begin
      adc_section <= adc_section + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      set_cnt    <= '0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      mean_valid <= 1'b0;
      for (int k = 0; k < NUM_SECT; k++) mean_r[k] <= '0;
    end else begin
      cal_done <= 1'b0;
      if ((state != ST_IDLE) && cal_abort) begin
        state    <= ST_IDLE;
        cal_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (acc_clr) begin
              state    <= ST_ALIGN;
              set_cnt  <= '0;
              cal_busy <= 1'b1;
            end
          end
          ST_ALIGN: begin
            if (acc_take) state <= ST_ACCUM;
          end
          ST_ACCUM: begin
            if (acc_take && last_sect) begin
              if (set_cnt == '1) begin
                // acc_d already holds the final sums, so the means land with cal_done.
                for (int k = 0; k < NUM_SECT; k++) mean_r[k] <= trunc_mean(acc_d[k]);
                state      <= ST_UPDATE;
                cal_done   <= 1'b1;
                mean_valid <= 1'b1;
                cal_busy   <= 1'b0;
              end else begin
                set_cnt <= set_cnt + 1'b1;
              end
            end
          end
          ST_UPDATE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mean_1 = mean_r[0];
  assign mean_2 = mean_r[1];
  assign mean_3 = mean_r[2];
  assign mean_4 = mean_r[3];

endmodule

// File: tb/tb_section_mean_calibrator.sv
// Randomized scoreboard bench for section_mean_calibrator (LOG2_AVG=2 main DUT,
// LOG2_AVG=10 instance for the full-scale averaging case).
module tb_section_mean_calibrator;

  localparam int NAVG  = 4;
  localparam int NBIG  = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cal_start, cal_abort, sample_valid;
  logic [15:0] sample_data;
  logic [1:0]  adc_section;
  logic        cal_busy, cal_done, mean_valid;
  logic [31:0] mean_1, mean_2, mean_3, mean_4;

  logic        b_start, b_abort, b_valid;
  logic [15:0] b_data;
  logic [1:0]  b_section;
  logic        b_busy, b_done, b_mv;
  logic [31:0] b_m1, b_m2, b_m3, b_m4;

  section_mean_calibrator #(.DATA_W(16), .LOG2_AVG(2), .MEAN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .cal_abort(cal_abort),
    .sample_valid(sample_valid), .sample_data(sample_data), .adc_section(adc_section),
    .cal_busy(cal_busy), .cal_done(cal_done), .mean_valid(mean_valid),
    .mean_1(mean_1), .mean_2(mean_2), .mean_3(mean_3), .mean_4(mean_4));

  section_mean_calibrator #(.DATA_W(16), .LOG2_AVG(10), .MEAN_W(32)) dut_big (
    .clk(clk), .rst_n(rst_n), .cal_start(b_start), .cal_abort(b_abort),
    .sample_valid(b_valid), .sample_data(b_data), .adc_section(b_section),
    .cal_busy(b_busy), .cal_done(b_done), .mean_valid(b_mv),
    .mean_1(b_m1), .mean_2(b_m2), .mean_3(b_m3), .mean_4(b_m4));

  int n_chk = 0;
  int n_fail = 0;
  int m_sec = 0;
  logic [127:0] exp_q[$];
  logic [127:0] cur_mean = '0;
  logic         exp_mv = 1'b0;
  logic [127:0] mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] gen(input int mode, input int sec, input int idx);
    case (mode)
      0:       return 16'(100 * (sec + 1));
      2:       return (sec == 0) ? ((idx == 0) ? 16'd1 : 16'd2) : 16'd0;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // Scoreboard monitor: new coefficients are expected only with cal_done.
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      exp_q.delete();
      cur_mean <= '0;
      exp_mv   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cal_done === 1'b1) begin
        chk("done_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("means_on_done", {mean_4, mean_3, mean_2, mean_1}, mon_e);
          chk("mean_valid_on_done", 128'(mean_valid), 128'(1));
          cur_mean <= mon_e;
          exp_mv   <= 1'b1;
        end
      end else begin
        chk("means_stable", {mean_4, mean_3, mean_2, mean_1}, cur_mean);
        chk("mean_valid_hold", 128'(mean_valid), 128'(exp_mv));
      end
    end
  end

  task automatic idle_valids(input int n);
    for (int i = 0; i < n; i++) begin
      chk("adc_section", 128'(adc_section), 128'(m_sec));
      sample_valid = 1'b1;
      sample_data  = gen(3, m_sec, 0);
      cyc();
      m_sec = (m_sec + 1) % 4;
    end
    sample_valid = 1'b0;
  endtask

  task automatic align_to0();
    while (m_sec != 0) idle_valids(1);
  endtask

  // One calibration run; reference means are plain per-section sums / NAVG.
  task automatic run_cal(input int mode, input int gap_pct, input int abort_at, input bit mid_start);
    int sums[4];
    int cnt[4];
    int taken;
    int issued;
    int lat;
    bit aligned;
    logic [15:0] d;
    for (int s = 0; s < 4; s++) begin sums[s] = 0; cnt[s] = 0; end
    taken = 0; issued = 0; aligned = 1'b0;
    cal_start = 1'b1; sample_valid = 1'b0;
    cyc();
    cal_start = 1'b0;
    chk("busy_rise", 128'(cal_busy), 128'(1));
    while (taken < 4 * NAVG) begin
      if ($urandom_range(99) < gap_pct) begin
        sample_valid = 1'b0;
        cyc();
        continue;
      end
      issued++;
      chk("adc_section", 128'(adc_section), 128'(m_sec));
      d = gen(mode, m_sec, cnt[m_sec]);
      sample_valid = 1'b1;
      sample_data  = d;
      cal_start    = mid_start && (issued == 6);
      if (issued == abort_at) begin
        cal_abort = 1'b1;
        cyc();
        cal_abort = 1'b0; sample_valid = 1'b0; cal_start = 1'b0;
        m_sec = (m_sec + 1) % 4;
        chk("busy_after_abort", 128'(cal_busy), 128'(0));
        cyc();
        return;
      end
      if (aligned || m_sec == 0) begin
        aligned = 1'b1;
        sums[m_sec] += int'(d);
        cnt[m_sec]++;
        taken++;
      end
      m_sec = (m_sec + 1) % 4;
      if (taken == 4 * NAVG)
        exp_q.push_back({32'(sums[3] / NAVG), 32'(sums[2] / NAVG),
                         32'(sums[1] / NAVG), 32'(sums[0] / NAVG)});
      cyc();
      cal_start = 1'b0;
    end
    sample_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cal_done === 1'b1) begin lat = i; break; end
    end
    chk("done_latency", 128'(lat), 128'(0));
    chk("busy_fall", 128'(cal_busy), 128'(0));
    cyc();
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_ctrl"}, 128'({adc_section, cal_busy, cal_done, mean_valid}), 128'(0));
    chk({name, "_means"}, {mean_4, mean_3, mean_2, mean_1}, 128'(0));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; cal_start = 1'b0; cal_abort = 1'b0; sample_valid = 1'b0; sample_data = '0;
    b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (2) cyc();
    chk_reset_state("reset");
    rst_n = 1'b1;
    cyc();

    // Constant sections, truncation, misaligned start with gaps, random data.
    run_cal(0, 0, 0, 1'b0);
    run_cal(2, 0, 0, 1'b0);
    idle_valids(2);
    run_cal(0, 50, 0, 1'b0);
    run_cal(3, 30, 0, 1'b0);

    // Aborts: mid-run, and in the cycle of the final sample; then a clean run.
    run_cal(0, 0, 0, 1'b0);
    run_cal(3, 0, 9, 1'b0);
    align_to0();
    run_cal(3, 0, 16, 1'b0);
    run_cal(3, 20, 0, 1'b0);

    // Start during ACCUM is ignored; abort+start together in IDLE stays idle.
    run_cal(3, 0, 0, 1'b1);
    cal_start = 1'b1; cal_abort = 1'b1;
    cyc();
    cal_start = 1'b0; cal_abort = 1'b0;
    chk("abort_start_idle", 128'(cal_busy), 128'(0));
    idle_valids(8);
    chk("abort_start_idle_late", 128'(cal_busy), 128'(0));

    // Reset in the middle of an accumulation, then section wrap.
    align_to0();
    cal_start = 1'b1;
    cyc();
    cal_start = 1'b0;
    sample_valid = 1'b1; sample_data = 16'd777;
    repeat (6) cyc();
    sample_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk_reset_state("mid_reset");
    rst_n = 1'b1;
    m_sec = 0;
    for (int i = 0; i < 8; i++) begin
      chk("sec_wrap", 128'(adc_section), 128'(i % 4));
      sample_valid = 1'b1;
      cyc();
    end
    sample_valid = 1'b0;
    chk("sec_wrap_end", 128'(adc_section), 128'(0));

    // Full-scale samples with 1024-sample averaging.
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    chk("big_busy", 128'(b_busy), 128'(1));
    b_valid = 1'b1; b_data = 16'hFFFF;
    repeat (4 * NBIG) cyc();
    b_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_done === 1'b1) begin seen = 1; break; end
    end
    chk("big_done_seen", 128'(seen), 128'(1));
    chk("big_means", {b_m4, b_m3, b_m2, b_m1}, {4{32'd65535}});
    chk("big_mean_valid", 128'(b_mv), 128'(1));
    cyc();

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
